// File: rtl/if_fetch_queue.sv
// if_fetch_queue
//   IF stage with several instruction-SRAM reads in flight. Fetches are held
//   in program order in a DEPTH-entry queue ({pc, inst, ex, ex_code, done});
//   in-order data_ok responses are paired with their slots through a small
//   pend queue of slot indices. On a flush, reads still on the bus are counted
//   in cancel_cnt and their responses are dropped, while new requests may
//   already be accepted.
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req_fire/pc/ex/ex_code  fetch handed over by preIF (legal when IF_allowin)
//   inst_sram_data_ok/rdata in-order read response
//   wb_ex, ertn_flush, br_cancel  flush sources
//   ID_allowin          ID accepts the head entry
//   IF_allowin          preIF may fire this cycle
//   IF_to_ID_valid/BUS  head entry {pc, inst, ex, ex_code}, zero when invalid
//   IO_cnt              reads on the bus (live + cancelled)
module if_fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_fire,
  input  logic [31:0] req_pc,
  input  logic        req_ex,
  input  logic [14:0] req_ex_code,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        wb_ex,
  input  logic        ertn_flush,
  input  logic        br_cancel,
  input  logic        ID_allowin,
  output logic        IF_allowin,
  output logic        IF_to_ID_valid,
  output logic [79:0] IF_to_ID_BUS,
  output logic [3:0]  IO_cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [3:0]    MAX_C   = 4'(MAX_OUT);
  localparam logic [PW-1:0] P_LAST  = PW'(MAX_OUT - 1);

  // entry storage
  logic [31:0] pc_q   [DEPTH];
  logic [31:0] inst_q [DEPTH];
  logic [14:0] exc_q  [DEPTH];
  logic        ex_q   [DEPTH];
  logic [DEPTH-1:0] done_q;

  // queue / pend / cancel bookkeeping
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] pq_q [MAX_OUT];
  logic [PW-1:0] ph_q, ph_d, pt_q, pt_d;
  logic [3:0]    pend_q, pend_d, cancel_q, cancel_d;

  logic flush, vld, dok, fill, drop, enq, enq_rd, deq, bus_issue;
  logic [AW-1:0] fill_slot;
  logic [3:0]    io;

  function automatic logic [PW-1:0] pnxt(input logic [PW-1:0] p);
    return (p == P_LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    flush      = wb_ex | ertn_flush | br_cancel;
    io         = pend_q + cancel_q;
    // occupancy check is on registered count: a same-cycle dequeue does not free a slot
    IF_allowin = (cnt_q < DEPTH_C) && (io < MAX_C) && !flush;
    vld        = (cnt_q != '0) && done_q[rd_q] && !flush;
    dok        = inst_sram_data_ok && (io != '0);
    drop       = dok && (cancel_q != '0);
    fill       = dok && (cancel_q == '0);
    fill_slot  = pq_q[ph_q];
    enq        = req_fire && IF_allowin;
    enq_rd     = enq && !req_ex;
    deq        = vld && ID_allowin;
    // a read preIF put on the bus in the flush cycle must still be drained
    bus_issue  = req_fire && !req_ex;
  end

  assign IF_to_ID_valid = vld;
  assign IO_cnt         = io;
  assign IF_to_ID_BUS   = vld ? {pc_q[rd_q], inst_q[rd_q], ex_q[rd_q], exc_q[rd_q]} : '0;

  always_comb begin
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    ph_d     = ph_q;
    pt_d     = pt_q;
    pend_d   = pend_q;
    cancel_d = cancel_q;
    if (flush) begin
      cnt_d    = '0;
      wr_d     = '0;
      rd_d     = '0;
      ph_d     = '0;
      pt_d     = '0;
      pend_d   = '0;
      // every read still on the bus becomes stale; a response this cycle retires one
      cancel_d = cancel_q + pend_q + {3'b0, bus_issue} - {3'b0, dok};
    end else begin
      cnt_d  = cnt_q + {{AW{1'b0}}, enq} - {{AW{1'b0}}, deq};
      if (enq)    wr_d = wr_q + AW'(1);
      if (deq)    rd_d = rd_q + AW'(1);
      if (enq_rd) pt_d = pnxt(pt_q);
      if (fill)   ph_d = pnxt(ph_q);
      pend_d = pend_q + {3'b0, enq_rd} - {3'b0, fill};
      if (drop)   cancel_d = cancel_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      ph_q     <= '0;
      pt_q     <= '0;
      pend_q   <= '0;
      cancel_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      ph_q     <= ph_d;
      pt_q     <= pt_d;
      pend_q   <= pend_d;
      cancel_q <= cancel_d;
    end
  end

  // pend queue payload: slot index of each live read, no reset needed
  always_ff @(posedge clk) begin
    if (!reset && enq_rd) pq_q[pt_q] <= wr_q;
  end

  // entries; enq and fill never hit the same slot (queue not full on enq)
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset || flush)                   done_q[i] <= 1'b0;
      else if (enq && wr_q == AW'(i))       done_q[i] <= req_ex;
      else if (fill && fill_slot == AW'(i)) done_q[i] <= 1'b1;

      if (enq && wr_q == AW'(i)) begin
        pc_q[i]  <= req_pc;
        ex_q[i]  <= req_ex;
        exc_q[i] <= req_ex_code;
        if (req_ex) inst_q[i] <= '0;
      end else if (fill && fill_slot == AW'(i)) begin
        inst_q[i] <= inst_sram_rdata;
      end
    end
  end

  // illegal handshakes are ignored by the logic above; flag them in simulation
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(inst_sram_data_ok && io == '0));
      assert (!(req_fire && !IF_allowin && !flush));
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios plus a randomized phase, all
// checked cycle by cycle against a queue-based reference model.
module tb_if_fetch_queue;
  localparam int DEPTH = 4, MAX_OUT = 2;

  logic clk = 0, reset, req_fire, req_ex, data_ok, wb_ex, ertn_flush, br_cancel, ID_allowin;
  logic [31:0] req_pc, rdata;
  logic [14:0] req_ex_code;
  logic IF_allowin, IF_to_ID_valid;
  logic [79:0] IF_to_ID_BUS;
  logic [3:0] IO_cnt;

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset), .req_fire(req_fire), .req_pc(req_pc), .req_ex(req_ex),
    .req_ex_code(req_ex_code), .inst_sram_data_ok(data_ok), .inst_sram_rdata(rdata),
    .wb_ex(wb_ex), .ertn_flush(ertn_flush), .br_cancel(br_cancel), .ID_allowin(ID_allowin),
    .IF_allowin(IF_allowin), .IF_to_ID_valid(IF_to_ID_valid), .IF_to_ID_BUS(IF_to_ID_BUS),
    .IO_cnt(IO_cnt));

  // reference model: entries in program order, bus reads in order (-1 = stale)
  typedef struct {
    logic [31:0] pc; logic [31:0] inst; logic ex; logic [14:0] code; bit done; int id;
  } ent_t;
  ent_t mq[$];
  int   inflt[$];
  int   nid = 0;
  int   tests = 0, fails = 0;
  logic [79:0] got[$];
  int   io_log[$];

  function automatic bit m_fl();
    return wb_ex | ertn_flush | br_cancel;
  endfunction
  function automatic bit e_valid();
    return !m_fl() && mq.size() > 0 && mq[0].done;
  endfunction
  function automatic bit e_allow();
    return mq.size() < DEPTH && inflt.size() < MAX_OUT && !m_fl();
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 0; req_fire = 0; req_pc = 0; req_ex = 0; req_ex_code = 0;
    data_ok = 0; rdata = 0; wb_ex = 0; ertn_flush = 0; br_cancel = 0; ID_allowin = 1;
  endtask

  task automatic fire(input logic [31:0] pc);
    req_fire = 1; req_pc = pc;
  endtask

  // inputs are set just after a negedge; check, advance model, move to next negedge
  task automatic tick();
    bit v, a;
    int id;
    ent_t e;
    #1;
    v = e_valid();
    a = e_allow();
    chk("valid", 80'(IF_to_ID_valid), 80'(v));
    chk("allowin", 80'(IF_allowin), 80'(a));
    chk("io_cnt", 80'(IO_cnt), 80'(inflt.size()));
    if (v) chk("bus", IF_to_ID_BUS, {mq[0].pc, mq[0].inst, mq[0].ex, mq[0].code});
    if (v && ID_allowin) got.push_back(IF_to_ID_BUS);
    io_log.push_back(int'(IO_cnt));
    if (reset) begin
      mq.delete();
      inflt.delete();
    end else begin
      if (data_ok && inflt.size() > 0) begin
        id = inflt.pop_front();
        if (!m_fl() && id >= 0)
          foreach (mq[i]) if (mq[i].id == id) begin mq[i].inst = rdata; mq[i].done = 1; end
      end
      if (m_fl()) begin
        foreach (inflt[i]) inflt[i] = -1;
        if (req_fire && !req_ex) inflt.push_back(-1);
        mq.delete();
      end else begin
        if (v && ID_allowin) e = mq.pop_front();
        if (req_fire && a) begin
          e.pc = req_pc; e.inst = req_ex ? 32'h0 : 32'hx; e.ex = req_ex;
          e.code = req_ex_code; e.done = req_ex; e.id = nid;
          if (!req_ex) inflt.push_back(nid);
          nid++;
          mq.push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int n, mx;
    int io_exp[5];
    idle();
    reset = 1;
    @(negedge clk); @(negedge clk);
    idle();
    chk("rst_valid", 80'(IF_to_ID_valid), 80'(0));
    chk("rst_allowin", 80'(IF_allowin), 80'(1));
    chk("rst_io", 80'(IO_cnt), 80'(0));
    chk("rst_bus", IF_to_ID_BUS, 80'(0));

    // T1 back-to-back, data_ok two cycles after each request
    got.delete(); io_log.delete();
    idle(); fire(32'h1C000000); tick();
    idle(); fire(32'h1C000004); tick();
    idle(); data_ok = 1; rdata = 32'hA0000000; tick();
    idle(); data_ok = 1; rdata = 32'hA0000004; fire(32'h1C000008); tick();
    idle(); tick();
    idle(); data_ok = 1; rdata = 32'hA0000008; tick();
    idle(); tick(); tick();
    chk("t1_cnt", 80'(got.size()), 80'(3));
    for (int i = 0; i < 3 && i < got.size(); i++)
      chk("t1_entry", got[i], {32'h1C000000 + 32'(4*i), 32'hA0000000 + 32'(4*i), 1'b0, 15'h0});
    mx = 0;
    foreach (io_log[i]) if (io_log[i] > mx) mx = io_log[i];
    chk("t1_io_peak", 80'(mx), 80'(2));

    // T2 fill the queue with ID stalled, then drain
    got.delete(); n = 0;
    for (int k = 0; k < 20; k++) begin
      idle(); ID_allowin = 0;
      if (!e_allow()) break;
      fire(32'h1C001000 + 32'(4*n));
      if (inflt.size() > 0) begin data_ok = 1; rdata = $urandom; end
      tick(); n++;
    end
    chk("t2_held", 80'(n), 80'(DEPTH));
    for (int k = 0; k < 10 && inflt.size() > 0; k++) begin
      idle(); ID_allowin = 0; data_ok = 1; rdata = $urandom; tick();
    end
    for (int k = 0; k < 4; k++) begin idle(); tick(); end
    chk("t2_drained", 80'(got.size()), 80'(DEPTH));
    for (int i = 0; i < DEPTH && i < got.size(); i++) begin
      logic [79:0] g;
      g = got[i];
      chk("t2_order", 80'(g[79:48]), 80'(32'h1C001000 + 32'(4*i)));
    end

    // T3 branch cancel with two reads pending
    got.delete(); io_log.delete();
    idle(); fire(32'h1C000040); tick();
    idle(); fire(32'h1C000044); tick();
    idle(); br_cancel = 1; tick();
    idle(); data_ok = 1; rdata = 32'hDEAD0001; tick();
    idle(); data_ok = 1; rdata = 32'hDEAD0002; fire(32'h1C000100); tick();
    idle(); data_ok = 1; rdata = 32'hC0DE0100; tick();
    idle(); tick(); tick();
    io_exp = '{2, 2, 1, 1, 0};
    for (int i = 0; i < 5; i++) chk("t3_io_seq", 80'(io_log[i+2]), 80'(io_exp[i]));
    chk("t3_cnt", 80'(got.size()), 80'(1));
    if (got.size() > 0) chk("t3_entry", got[0], {32'h1C000100, 32'hC0DE0100, 1'b0, 15'h0});

    // T4 exception entry behind a pending read
    got.delete();
    idle(); fire(32'h1C000200); tick();
    idle(); fire(32'h1C000204); req_ex = 1; req_ex_code = 15'h0008; tick();
    idle(); tick(); tick();
    idle(); data_ok = 1; rdata = 32'h12345678; tick();
    idle(); tick(); tick(); tick();
    chk("t4_cnt", 80'(got.size()), 80'(2));
    if (got.size() > 1) begin
      chk("t4_read", got[0], {32'h1C000200, 32'h12345678, 1'b0, 15'h0});
      chk("t4_ex", got[1], {32'h1C000204, 32'h0, 1'b1, 15'h0008});
    end

    // T5 flush coincident with data_ok and req_fire
    got.delete();
    idle(); fire(32'h1C000300); tick();
    idle(); wb_ex = 1; data_ok = 1; rdata = 32'hBAD00300; fire(32'h1C000304); tick();
    chk("t5_io", 80'(IO_cnt), 80'(1));
    chk("t5_empty", 80'(IF_to_ID_valid), 80'(0));
    idle(); data_ok = 1; rdata = 32'hBAD00304; tick();
    idle(); tick(); tick();
    chk("t5_no_stale", 80'(got.size()), 80'(0));

    // T6 reset with two reads pending
    idle(); fire(32'h1C000400); tick();
    idle(); fire(32'h1C000404); tick();
    idle(); reset = 1; tick();
    idle();
    chk("t6_valid", 80'(IF_to_ID_valid), 80'(0));
    chk("t6_allowin", 80'(IF_allowin), 80'(1));
    chk("t6_io", 80'(IO_cnt), 80'(0));
    chk("t6_bus", IF_to_ID_BUS, 80'(0));

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      idle();
      ID_allowin = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 15);
      if (r == 0) wb_ex = 1;
      else if (r == 1) ertn_flush = 1;
      else if (r == 2) br_cancel = 1;
      if ($urandom_range(0, 299) == 0) reset = 1;
      if (inflt.size() > 0 && $urandom_range(0, 1) == 1) begin data_ok = 1; rdata = $urandom; end
      if (e_allow() ? ($urandom_range(0, 2) != 0)
                    : (m_fl() && inflt.size() < MAX_OUT && $urandom_range(0, 2) == 0)) begin
        req_fire = 1;
        req_pc = $urandom & 32'hFFFFFFFC;
        req_ex = ($urandom_range(0, 4) == 0);
        req_ex_code = 15'($urandom);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
